// File: rtl/sprite_draw_sequencer_if.sv
// Queue head, sprite storage read port and frame buffer write port of the sprite draw sequencer.
// master = sequencer side, slave = queue/storage/frame-buffer side.
interface sprite_draw_sequencer_if #(
    parameter int SPRITE_ADDR_SIZE = 13,
    parameter int FB_WIDTH         = 640,
    parameter int FB_HEIGHT        = 480
);
    logic                         is_empty;
    logic [7:0]                   sprite_id;
    logic [15:0]                  sprite_x;
    logic [15:0]                  sprite_y;
    logic [7:0]                   sprite_scale;
    logic                         dequeue;
    logic                         sprite_r_en;
    logic [SPRITE_ADDR_SIZE:0]    sprite_r_addr;
    logic [3:0]                   sprite_r_data;
    logic                         fb_w_en;
    logic [$clog2(FB_WIDTH)-1:0]  fb_x;
    logic [$clog2(FB_HEIGHT)-1:0] fb_y;
    logic [3:0]                   fb_w_data;
    logic                         fb_w_ready;

    modport master (
        input  is_empty, sprite_id, sprite_x, sprite_y, sprite_scale, sprite_r_data, fb_w_ready,
        output dequeue, sprite_r_en, sprite_r_addr, fb_w_en, fb_x, fb_y, fb_w_data
    );

    modport slave (
        output is_empty, sprite_id, sprite_x, sprite_y, sprite_scale, sprite_r_data, fb_w_ready,
        input  dequeue, sprite_r_en, sprite_r_addr, fb_w_en, fb_x, fb_y, fb_w_data
    );
endinterface

// File: rtl/sprite_draw_sequencer.sv
// Drains the sprite queue once per frame, rendering scaled, clipped, transparency-filtered pixels.
// Visible pixel 4 cycles, transparent 3, clipped 2; a pending write holds until fb_w_ready.
module sprite_draw_sequencer #(
    parameter int SPRITE_NUM       = 16,
    parameter int SPRITE_SIZE      = 32,
    parameter int SPRITE_ADDR_SIZE = 13,
    parameter int FB_WIDTH         = 640,
    parameter int FB_HEIGHT        = 480
) (
    input  logic                    sys_clock,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    sprite_draw_sequencer_if.master bus
);
    localparam int SW = $clog2(SPRITE_SIZE);
    localparam int DW = SW + 8;
    localparam int AW = SPRITE_ADDR_SIZE + 1;
    localparam int XW = $clog2(FB_WIDTH);
    localparam int YW = $clog2(FB_HEIGHT);

    typedef enum logic [2:0] {IDLE, FETCH, READ, WAIT, WRITE, NEXT, FINISH} state_t;

    state_t          state_q, state_d;
    logic [7:0]      id_q, id_d;
    logic [15:0]     x_q, x_d, y_q, y_d;
    logic [7:0]      scale_q, scale_d;
    logic [DW-1:0]   dx_q, dx_d, dy_q, dy_d;
    logic [7:0]      subx_q, subx_d, suby_q, suby_d;
    logic [SW-1:0]   sx_q, sx_d, sy_q, sy_d;
    logic [3:0]      col_q, col_d;
    logic [XW-1:0]   px_q, px_d;
    logic [YW-1:0]   py_q, py_d;

    logic signed [16:0] scr_x, scr_y;
    logic               on_screen;
    logic [DW-1:0]      last;
    logic [AW-1:0]      rd_addr;

    // Screen position is evaluated one bit wider than the queue coordinates so that large offsets cannot wrap.
    assign scr_x = $signed({x_q[15], x_q}) + $signed({{(17-DW){1'b0}}, dx_q});
    assign scr_y = $signed({y_q[15], y_q}) + $signed({{(17-DW){1'b0}}, dy_q});
    assign on_screen = !scr_x[16] && (scr_x[15:0] < 16'(FB_WIDTH)) &&
                       !scr_y[16] && (scr_y[15:0] < 16'(FB_HEIGHT));
    assign last    = DW'(SPRITE_SIZE) * DW'(scale_q) - DW'(1);
    assign rd_addr = AW'(id_q) * AW'(SPRITE_SIZE * SPRITE_SIZE) + AW'(sy_q) * AW'(SPRITE_SIZE) + AW'(sx_q);

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        x_d      = x_q;
        y_d      = y_q;
        scale_d  = scale_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        subx_d   = subx_q;
        suby_d   = suby_q;
        sx_d     = sx_q;
        sy_d     = sy_q;
        col_d    = col_q;
        px_d     = px_q;
        py_d     = py_q;
        busy              = (state_q != IDLE);
        done              = 1'b0;
        bus.dequeue       = 1'b0;
        bus.sprite_r_en   = 1'b0;
        bus.sprite_r_addr = '0;
        bus.fb_w_en       = 1'b0;
        bus.fb_x          = '0;
        bus.fb_y          = '0;
        bus.fb_w_data     = '0;

        case (state_q)
            IDLE: if (start) state_d = FETCH;
            FETCH: begin
                if (bus.is_empty) begin
                    state_d = FINISH;
                end else begin
                    bus.dequeue = 1'b1;
                    id_d    = bus.sprite_id;
                    x_d     = bus.sprite_x;
                    y_d     = bus.sprite_y;
                    scale_d = (bus.sprite_scale == 8'd0) ? 8'd1 : bus.sprite_scale;
                    dx_d    = '0;
                    dy_d    = '0;
                    subx_d  = '0;
                    suby_d  = '0;
                    sx_d    = '0;
                    sy_d    = '0;
                    // Out-of-range ids are popped and discarded.
                    state_d = (int'(bus.sprite_id) < SPRITE_NUM) ? READ : FETCH;
                end
            end
            READ: begin
                px_d = scr_x[XW-1:0];
                py_d = scr_y[YW-1:0];
                if (on_screen) begin
                    bus.sprite_r_en   = 1'b1;
                    bus.sprite_r_addr = rd_addr;
                    state_d = WAIT;
                end else begin
                    state_d = NEXT;
                end
            end
            WAIT: begin
                col_d   = bus.sprite_r_data;
                state_d = (bus.sprite_r_data == 4'd0) ? NEXT : WRITE;
            end
            WRITE: begin
                bus.fb_w_en   = 1'b1;
                bus.fb_x      = px_q;
                bus.fb_y      = py_q;
                bus.fb_w_data = col_q;
                if (bus.fb_w_ready) state_d = NEXT;
            end
            NEXT: begin
                state_d = READ;
                if (dx_q == last) begin
                    if (dy_q == last) begin
                        state_d = FETCH;
                    end else begin
                        dx_d   = '0;
                        subx_d = '0;
                        sx_d   = '0;
                        dy_d   = dy_q + DW'(1);
                        if (suby_q == scale_q - 8'd1) begin
                            suby_d = '0;
                            sy_d   = sy_q + SW'(1);
                        end else begin
                            suby_d = suby_q + 8'd1;
                        end
                    end
                end else begin
                    dx_d = dx_q + DW'(1);
                    if (subx_q == scale_q - 8'd1) begin
                        subx_d = '0;
                        sx_d   = sx_q + SW'(1);
                    end else begin
                        subx_d = subx_q + 8'd1;
                    end
                end
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            id_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            scale_q <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            subx_q  <= '0;
            suby_q  <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            col_q   <= '0;
            px_q    <= '0;
            py_q    <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            x_q     <= x_d;
            y_q     <= y_d;
            scale_q <= scale_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            subx_q  <= subx_d;
            suby_q  <= suby_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            col_q   <= col_d;
            px_q    <= px_d;
            py_q    <= py_d;
        end
    end
endmodule

// File: tb/tb_sprite_draw_sequencer.sv
// Scoreboard bench: a reference renderer fills the expected-write queue, a negedge monitor checks each accepted write.
module tb_sprite_draw_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy, done;

    sprite_draw_sequencer_if bus ();

    sprite_draw_sequencer dut (
        .sys_clock (clk),
        .reset     (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct {logic [7:0] id; logic [15:0] x; logic [15:0] y; logic [7:0] sc;} ent_t;
    typedef struct {int x; int y; int c;} wr_t;

    ent_t       sq[$];
    wr_t        exp_q[$];
    logic [3:0] mem [0:16383];
    int checks = 0;
    int errors = 0;
    int exp_reads, exp_deq, reads, deqs, dones, first_rd, nwr;
    wr_t wr0, wr1, wr_last;
    logic pop_pend = 1'b0;

    task automatic refresh_head();
        if (sq.size() == 0) begin
            bus.is_empty     = 1'b1;
            bus.sprite_id    = '0;
            bus.sprite_x     = '0;
            bus.sprite_y     = '0;
            bus.sprite_scale = '0;
        end else begin
            bus.is_empty     = 1'b0;
            bus.sprite_id    = sq[0].id;
            bus.sprite_x     = sq[0].x;
            bus.sprite_y     = sq[0].y;
            bus.sprite_scale = sq[0].sc;
        end
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference renderer: integer division stands in for the scaled walk.
    task automatic push_sprite(input int id, input logic [15:0] x, input logic [15:0] y, input int sc);
        int s, xs, ys, px, py, c;
        ent_t e;
        e.id = 8'(id); e.x = x; e.y = y; e.sc = 8'(sc);
        sq.push_back(e);
        exp_deq++;
        if (id < 16) begin
            s  = (sc == 0) ? 1 : sc;
            xs = $signed(x);
            ys = $signed(y);
            for (int dy = 0; dy < 32 * s; dy++) begin
                for (int dx = 0; dx < 32 * s; dx++) begin
                    px = xs + dx;
                    py = ys + dy;
                    if (px >= 0 && px < 640 && py >= 0 && py < 480) begin
                        exp_reads++;
                        c = int'(mem[id * 1024 + (dy / s) * 32 + dx / s]);
                        if (c != 0) exp_q.push_back('{px, py, c});
                    end
                end
            end
        end
        refresh_head();
    endtask

    task automatic frame_begin();
        exp_reads = 0; exp_deq = 0; reads = 0; deqs = 0; dones = 0;
        first_rd = -1; nwr = 0;
        exp_q.delete();
    endtask

    task automatic run_frame(input string tag);
        int n;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (dones == 0 && n < 40000) begin
            @(posedge clk);
            n++;
        end
        if (dones == 0) begin
            checks++; errors++;
            $display("FAIL %s_timeout actual=no_done required=done", tag);
        end
        repeat (5) @(posedge clk);
        #1;
        chk({tag, "_done_count"}, dones, 1);
        chk({tag, "_reads"}, reads, exp_reads);
        chk({tag, "_dequeues"}, deqs, exp_deq);
        chk({tag, "_missing_writes"}, exp_q.size(), 0);
        chk({tag, "_busy_after"}, int'(busy), 0);
    endtask

    task automatic stall_check();
        int n = 0;
        while (!bus.fb_w_en && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.fb_w_en) begin
            checks++; errors++;
            $display("FAIL t5_no_write actual=0 required=1");
        end else begin
            for (int i = 0; i < 5; i++) begin
                @(posedge clk); #1;
                chk("t5_hold_en", int'(bus.fb_w_en), 1);
                chk("t5_hold_x", int'(bus.fb_x), 300);
                chk("t5_hold_y", int'(bus.fb_y), 200);
                chk("t5_hold_data", int'(bus.fb_w_data), 5);
                chk("t5_no_rd_deq", int'({bus.sprite_r_en, bus.dequeue}), 0);
            end
        end
        bus.fb_w_ready = 1'b1;
    endtask

    always @(posedge clk) if (bus.sprite_r_en) bus.sprite_r_data <= mem[bus.sprite_r_addr];

    always @(posedge clk) begin
        #1;
        if (pop_pend) begin
            pop_pend = 1'b0;
            if (sq.size() > 0) void'(sq.pop_front());
            refresh_head();
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.dequeue) begin
                deqs++;
                pop_pend = 1'b1;
                checks++;
                if (bus.is_empty) begin
                    errors++;
                    $display("FAIL dequeue_when_empty actual=1 required=0");
                end
            end
            if (bus.sprite_r_en) begin
                reads++;
                if (first_rd < 0) first_rd = int'(bus.sprite_r_addr);
                checks++;
                if (bus.fb_w_en) begin
                    errors++;
                    $display("FAIL rd_wr_overlap actual=1 required=0");
                end
            end
            if (bus.fb_w_en && bus.fb_w_ready) begin
                wr_t got, e;
                got = '{int'(bus.fb_x), int'(bus.fb_y), int'(bus.fb_w_data)};
                if (nwr == 0) wr0 = got;
                if (nwr == 1) wr1 = got;
                wr_last = got;
                nwr++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL write actual=(%0d,%0d,%0d) required=none", got.x, got.y, got.c);
                end else begin
                    e = exp_q.pop_front();
                    if (got != e) begin
                        errors++;
                        $display("FAIL write actual=(%0d,%0d,%0d) required=(%0d,%0d,%0d)",
                                 got.x, got.y, got.c, e.x, e.y, e.c);
                    end
                end
            end
            if (done) dones++;
        end
    end

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 4'd0;
        for (int sy = 0; sy < 32; sy++)
            for (int sx = 0; sx < 32; sx++)
                mem[2048 + sy * 32 + sx] = 4'((sx + 2 * sy + 5) & 15);
        bus.fb_w_ready = 1'b1;
        refresh_head();
        frame_begin();

        #12;
        chk("rst_ctrl", int'({busy, done, bus.dequeue, bus.sprite_r_en, bus.fb_w_en}), 0);
        chk("rst_bus", int'(bus.sprite_r_addr) + int'(bus.fb_x) + int'(bus.fb_y) + int'(bus.fb_w_data), 0);
        @(posedge clk); #1 rst = 1'b0;

        // 1: unscaled sprite, first read/write hand-checked
        frame_begin();
        push_sprite(2, 16'd10, 16'd20, 1);
        run_frame("t1");
        chk("t1_first_addr", first_rd, 2048);
        chk("t1_reads_const", reads, 1024);
        chk("t1_first_wr", wr0.x * 100000 + wr0.y * 100 + wr0.c, 10 * 100000 + 20 * 100 + 5);

        // 2: scale 2 replicates source pixels
        frame_begin();
        push_sprite(2, 16'd10, 16'd20, 2);
        run_frame("t2");
        chk("t2_reads_const", reads, 4096);
        chk("t2_wr0", wr0.x * 100000 + wr0.y * 100 + wr0.c, 10 * 100000 + 20 * 100 + 5);
        chk("t2_wr1", wr1.x * 100000 + wr1.y * 100 + wr1.c, 11 * 100000 + 20 * 100 + 5);
        chk("t2_last", wr_last.x * 100000 + wr_last.y * 100 + wr_last.c, 73 * 100000 + 83 * 100 + 2);

        // 3: clipped left and bottom
        frame_begin();
        push_sprite(2, 16'hFFFC, 16'd470, 1);
        run_frame("t3");
        chk("t3_reads_const", reads, 280);
        chk("t3_wr0", wr0.x * 100000 + wr0.y * 100 + wr0.c, 0 * 100000 + 470 * 100 + 9);

        // 4: dropped id then all-transparent sprite
        frame_begin();
        push_sprite(20, 16'd0, 16'd0, 1);
        push_sprite(3, 16'd100, 16'd100, 1);
        run_frame("t4");
        chk("t4_writes", nwr, 0);
        chk("t4_reads_const", reads, 1024);

        // 5: backpressure on the first write
        frame_begin();
        bus.fb_w_ready = 1'b0;
        push_sprite(2, 16'd300, 16'd200, 1);
        fork
            run_frame("t5");
            stall_check();
        join

        // 6a: empty queue
        frame_begin();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("t6_c1", int'({done, busy}), 1);
        @(posedge clk); #1;
        chk("t6_c2", int'({done, busy}), 3);
        @(posedge clk); #1;
        chk("t6_c3", int'({done, busy}), 0);
        chk("t6_deq", deqs, 0);

        // 6b: reset mid-sprite, then a fresh frame
        frame_begin();
        push_sprite(2, 16'd50, 16'd50, 1);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (200) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_ctrl", int'({busy, done, bus.dequeue, bus.sprite_r_en, bus.fb_w_en}), 0);
        chk("t6_rst_bus", int'(bus.sprite_r_addr) + int'(bus.fb_x) + int'(bus.fb_y) + int'(bus.fb_w_data), 0);
        @(posedge clk); #1 rst = 1'b0;
        pop_pend = 1'b0;
        sq.delete();
        refresh_head();
        frame_begin();
        push_sprite(2, 16'd600, 16'd460, 1);
        run_frame("t6_after");
        chk("t6_reads_const", reads, 640);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
